// File: rtl/motor_encoder_model_if.sv
// Drive and encoder-side signals of the motor/encoder emulator.
interface motor_encoder_model_if;
    logic        PWM;
    logic        enc_a;
    logic        enc_b;
    logic [15:0] speed_deg_s;
    logic [31:0] edge_count;

    // Controller side: drives PWM, observes the emulated encoder.
    modport master (
        output PWM,
        input  enc_a,
        input  enc_b,
        input  speed_deg_s,
        input  edge_count
    );

    // Model side: consumes PWM, produces the encoder outputs.
    modport slave (
        input  PWM,
        output enc_a,
        output enc_b,
        output speed_deg_s,
        output edge_count
    );
endinterface

// File: rtl/motor_encoder_model.sv
// Motor plus quadrature encoder emulator: PWM duty -> filtered speed -> encoder edges.
module motor_encoder_model #(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned LOG_WINDOW = 14,
    parameter int unsigned MAX_DEG_S  = 1440,
    parameter int unsigned LOG_TAU    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    motor_encoder_model_if.slave  bus
);

    localparam int unsigned WIN_W   = LOG_WINDOW;
    localparam int unsigned HIGH_W  = LOG_WINDOW + 1;
    localparam int unsigned SPEED_W = 16;
    localparam int unsigned DIFF_W  = SPEED_W + 1;
    localparam int unsigned PROD_W  = HIGH_W + 32;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned CNT_W   = 32;

    // The NCO may advance at most one quadrature step per clock.
    if (4 * MAX_DEG_S >= CLK_HZ) begin : g_bad_params
        $error("motor_encoder_model: 4*MAX_DEG_S must be below CLK_HZ");
    end

    logic                      sync1;
    logic                      sync2;
    logic [WIN_W-1:0]          win_cnt;
    logic [HIGH_W-1:0]         high_cnt;
    logic [HIGH_W-1:0]         latched;
    logic                      latch_vld;
    logic [SPEED_W-1:0]        target;
    logic                      tgt_vld;
    logic [SPEED_W-1:0]        speed;
    logic [ACC_W-1:0]          acc;
    logic                      enc_a;
    logic                      enc_b;
    logic [CNT_W-1:0]          edge_count;

    logic                      win_last_c;
    logic [SPEED_W-1:0]        target_c;
    logic signed [DIFF_W-1:0]  diff_c;
    logic signed [DIFF_W-1:0]  shifted_c;
    logic [SPEED_W-1:0]        speed_nxt_c;
    logic [SUM_W-1:0]          sum_c;
    logic                      step_c;

    assign win_last_c = (win_cnt == {WIN_W{1'b1}});
    assign target_c   = SPEED_W'((PROD_W'(latched) * PROD_W'(MAX_DEG_S)) >> LOG_WINDOW);
    assign diff_c     = DIFF_W'(target) - DIFF_W'(speed);
    assign shifted_c  = diff_c >>> LOG_TAU;
    assign sum_c      = SUM_W'(acc) + (SUM_W'(speed) << 2);
    assign step_c     = (sum_c >= SUM_W'(CLK_HZ));

    // Two-flop synchroniser for the asynchronous PWM pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.PWM;
            sync2 <= sync1;
        end
    end

    // Duty measurement: the final sample is folded into the latched sum directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            high_cnt  <= '0;
            latched   <= '0;
            latch_vld <= 1'b0;
        end else begin
            win_cnt   <= win_cnt + WIN_W'(1);
            latch_vld <= win_last_c;
            if (win_last_c) begin
                latched  <= high_cnt + HIGH_W'(sync2);
                high_cnt <= '0;
            end else begin
                high_cnt <= high_cnt + HIGH_W'(sync2);
            end
        end
    end

    // Duty to target speed, one cycle after the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            target  <= '0;
            tgt_vld <= 1'b0;
        end else begin
            tgt_vld <= latch_vld;
            if (latch_vld) begin
                target <= target_c;
            end
        end
    end

    // First-order filter step; falls back to unit steps so speed lands exactly on target.
    always_comb begin
        speed_nxt_c = speed;
        if (shifted_c != '0) begin
            speed_nxt_c = speed + SPEED_W'(shifted_c);
        end else if (diff_c != '0) begin
            speed_nxt_c = diff_c[DIFF_W-1] ? speed - SPEED_W'(1) : speed + SPEED_W'(1);
        end
    end

    // Speed register, updated once per window.
    always_ff @(posedge clk) begin
        if (rst) begin
            speed <= '0;
        end else if (tgt_vld) begin
            speed <= speed_nxt_c;
        end
    end

    // Phase accumulator and forward-only quadrature stepping; A rises on 00 -> 10.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            enc_a      <= 1'b0;
            enc_b      <= 1'b0;
            edge_count <= '0;
        end else if (step_c) begin
            acc   <= ACC_W'(sum_c - SUM_W'(CLK_HZ));
            enc_a <= ~enc_b;
            enc_b <= enc_a;
            if (!enc_a && !enc_b) begin
                edge_count <= edge_count + CNT_W'(1);
            end
        end else begin
            acc <= ACC_W'(sum_c);
        end
    end

    assign bus.enc_a       = enc_a;
    assign bus.enc_b       = enc_b;
    assign bus.speed_deg_s = speed;
    assign bus.edge_count  = edge_count;

endmodule

// File: tb/tb_motor_encoder_model.sv
// Directed bench for motor_encoder_model using scaled-down timing parameters.
module tb_motor_encoder_model;

    localparam int unsigned CLK_HZ     = 8000;
    localparam int unsigned LOG_WINDOW = 6;
    localparam int unsigned MAX_DEG_S  = 1440;
    localparam int          W          = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    motor_encoder_model_if bus0 ();
    motor_encoder_model_if bus3 ();

    motor_encoder_model #(
        .CLK_HZ(CLK_HZ), .LOG_WINDOW(LOG_WINDOW), .MAX_DEG_S(MAX_DEG_S), .LOG_TAU(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    motor_encoder_model #(
        .CLK_HZ(CLK_HZ), .LOG_WINDOW(LOG_WINDOW), .MAX_DEG_S(MAX_DEG_S), .LOG_TAU(3)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // PWM generators: period 16 clocks, h0/h3 clocks high per period.
    int h0 = 0;
    int h3 = 0;
    int ph = 0;
    initial begin
        bus0.PWM = 1'b0;
        bus3.PWM = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 16;
            bus0.PWM = (ph < h0);
            bus3.PWM = (ph < h3);
        end
    end

    // Reset as seen by the DUT at each active edge.
    logic rst_q = 1'b1;
    initial forever begin
        @(posedge clk);
        rst_q <= rst;
    end

    // Quadrature legality monitor and independent count of A rising edges.
    logic pa [2];
    logic pb [2];
    logic ca [2];
    logic cb [2];
    int   rises [2] = '{0, 0};
    int   quad_bad [2] = '{0, 0};
    initial forever begin
        @(negedge clk);
        ca[0] = bus0.enc_a; cb[0] = bus0.enc_b;
        ca[1] = bus3.enc_a; cb[1] = bus3.enc_b;
        for (int i = 0; i < 2; i++) begin
            if (rst_q) begin
                rises[i] = 0;
            end else begin
                if ({ca[i], cb[i]} != {pa[i], pb[i]} && {ca[i], cb[i]} != {~pb[i], pa[i]})
                    quad_bad[i]++;
                if (!pa[i] && ca[i])
                    rises[i]++;
            end
            pa[i] = ca[i];
            pb[i] = cb[i];
        end
    end

    typedef struct {
        int high16;
        int exp_speed;
    } vec_t;

    vec_t vecs [7];

    task automatic check_zero(input string tag, input logic a, input logic b,
                              input logic [15:0] s, input logic [31:0] e);
        check({tag, "_enc_a"}, 32'(a), 32'd0);
        check({tag, "_enc_b"}, 32'(b), 32'd0);
        check({tag, "_speed"}, 32'(s), 32'd0);
        check({tag, "_edges"}, e, 32'd0);
    endtask

    initial begin
        int e_start;
        int prev;
        int dec_cnt;
        int over_cnt;
        int nz_cnt;
        int chg_cnt;
        logic ha;
        logic hb;
        logic [31:0] he;

        vecs[0] = '{16, 1440};
        vecs[1] = '{8, 720};
        vecs[2] = '{4, 360};
        vecs[3] = '{12, 1080};
        vecs[4] = '{1, 90};
        vecs[5] = '{15, 1350};
        vecs[6] = '{0, 0};

        // Reset and idle with PWM low.
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_zero("rst0", bus0.enc_a, bus0.enc_b, bus0.speed_deg_s, bus0.edge_count);
        check_zero("rst3", bus3.enc_a, bus3.enc_b, bus3.speed_deg_s, bus3.edge_count);
        rst = 1'b0;
        repeat (3 * W) @(negedge clk);
        check_zero("idle0", bus0.enc_a, bus0.enc_b, bus0.speed_deg_s, bus0.edge_count);
        check_zero("idle3", bus3.enc_a, bus3.enc_b, bus3.speed_deg_s, bus3.edge_count);

        // Duty to speed with an unfiltered model.
        foreach (vecs[i]) begin
            h0 = vecs[i].high16;
            repeat (3 * W) @(negedge clk);
            check($sformatf("duty_%0d_of_16", vecs[i].high16),
                  32'(bus0.speed_deg_s), 32'(vecs[i].exp_speed));
        end

        // One emulated second at full speed gives MAX_DEG_S encoder edges.
        h0 = 16;
        repeat (3 * W) @(negedge clk);
        check("full_speed", 32'(bus0.speed_deg_s), 32'd1440);
        e_start = int'(bus0.edge_count);
        repeat (CLK_HZ) @(negedge clk);
        check_range("edges_per_second", int'(bus0.edge_count) - e_start, 1439, 1441);
        #1;
        check("edge_count_vs_rises0", bus0.edge_count, 32'(rises[0]));

        // Filtered rise to 50% duty: monotonic, no overshoot, exact settle.
        h3 = 8;
        prev = 0; dec_cnt = 0; over_cnt = 0;
        repeat (70 * W) begin
            @(negedge clk);
            if (int'(bus3.speed_deg_s) < prev) dec_cnt++;
            if (bus3.speed_deg_s > 16'd720) over_cnt++;
            prev = int'(bus3.speed_deg_s);
        end
        check("rise_decreases", 32'(dec_cnt), 32'd0);
        check("rise_overshoot", 32'(over_cnt), 32'd0);
        check("rise_settle", 32'(bus3.speed_deg_s), 32'd720);
        check("rise_moved", 32'(bus3.edge_count != 32'd0), 32'd1);

        // Filtered decay to zero, then encoder outputs freeze.
        h3 = 0;
        prev = int'(bus3.speed_deg_s); dec_cnt = 0;
        repeat (70 * W) begin
            @(negedge clk);
            if (int'(bus3.speed_deg_s) > prev) dec_cnt++;
            prev = int'(bus3.speed_deg_s);
        end
        check("decay_increases", 32'(dec_cnt), 32'd0);
        check("decay_settle", 32'(bus3.speed_deg_s), 32'd0);
        ha = bus3.enc_a; hb = bus3.enc_b; he = bus3.edge_count; chg_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus3.enc_a != ha || bus3.enc_b != hb || bus3.edge_count != he) chg_cnt++;
        end
        check("stopped_hold", 32'(chg_cnt), 32'd0);
        #1;
        check("edge_count_vs_rises3", bus3.edge_count, 32'(rises[1]));

        // One-cycle reset pulse while running at full speed.
        @(negedge clk);
        check("pre_pulse_speed", 32'(bus0.speed_deg_s), 32'd1440);
        rst = 1'b1;
        @(negedge clk);
        check_zero("pulse0", bus0.enc_a, bus0.enc_b, bus0.speed_deg_s, bus0.edge_count);
        rst = 1'b0;
        nz_cnt = 0;
        repeat (W + 1) begin
            @(negedge clk);
            if (bus0.speed_deg_s != 16'd0) nz_cnt++;
        end
        check("post_pulse_hold_zero", 32'(nz_cnt), 32'd0);
        // Two synchroniser cycles of the first window see the cleared flops: 62/64 high.
        @(negedge clk);
        check("post_pulse_first_window", 32'(bus0.speed_deg_s), 32'd1395);
        repeat (3 * W) @(negedge clk);
        check("post_pulse_full", 32'(bus0.speed_deg_s), 32'd1440);
        #1;
        check("edge_count_vs_rises_pulse", bus0.edge_count, 32'(rises[0]));

        check("quad_sequence0", 32'(quad_bad[0]), 32'd0);
        check("quad_sequence3", 32'(quad_bad[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
